// File: rtl/id_ex_reg.sv
// id_ex_reg: decode/execute pipeline register.
// Captures decode-stage controls, operands, immediate and destination each
// clock edge, with stall (hold), flush (bubble) and a saturating count of
// inserted bubbles.
// Optional feature: define COND_EXEC_EN to squash instructions whose
// condition field fails against the current NZCV flags.
module id_ex_reg #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              flush,
    input  logic              valid_in,
    input  logic              reg_write_enable_in,
    input  logic              mem_write_enable_in,
    input  logic              mem_to_reg_select_in,
    input  logic              alu_src_select_in,
    input  logic [1:0]        alu_control_in,
    input  logic              status_bits_in,
    input  logic [DATA_W-1:0] rn_data_in,
    input  logic [DATA_W-1:0] rm_data_in,
    input  logic [DATA_W-1:0] imm_in,
    input  logic [ADDR_W-1:0] rd_addr_in,
    input  logic [3:0]        cond_in,
    input  logic [3:0]        flags_in,
    output logic              reg_write_enable_out,
    output logic              mem_write_enable_out,
    output logic              mem_to_reg_select_out,
    output logic              alu_src_select_out,
    output logic [1:0]        alu_control_out,
    output logic              status_bits_out,
    output logic [DATA_W-1:0] rn_data_out,
    output logic [DATA_W-1:0] rm_data_out,
    output logic [DATA_W-1:0] imm_out,
    output logic [ADDR_W-1:0] rd_addr_out,
    output logic              valid_out,
    output logic              cond_fail_out,
    output logic [CNT_W-1:0]  bubble_cnt_out
);

    logic             cond_pass;
    logic             load_ok;
    logic [CNT_W-1:0] bubble_cnt_inc;

`ifdef COND_EXEC_EN
    logic flag_n, flag_z, flag_c, flag_v;
    assign {flag_n, flag_z, flag_c, flag_v} = flags_in;

    // Evaluate the instruction condition field against the NZCV flags
    always_comb begin
        cond_pass = 1'b0;
        case (cond_in)
            4'b0000: cond_pass = flag_z;
            4'b0001: cond_pass = !flag_z;
            4'b0010: cond_pass = flag_c;
            4'b0011: cond_pass = !flag_c;
            4'b0100: cond_pass = flag_n;
            4'b0101: cond_pass = !flag_n;
            4'b0110: cond_pass = flag_v;
            4'b0111: cond_pass = !flag_v;
            4'b1000: cond_pass = flag_c && !flag_z;
            4'b1001: cond_pass = !flag_c || flag_z;
            4'b1010: cond_pass = (flag_n == flag_v);
            4'b1011: cond_pass = (flag_n != flag_v);
            4'b1100: cond_pass = !flag_z && (flag_n == flag_v);
            4'b1101: cond_pass = flag_z || (flag_n != flag_v);
            4'b1110: cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    end
`else
    logic unused_cond;
    assign unused_cond = ^{cond_in, flags_in};
    assign cond_pass   = 1'b1;
`endif

    // A load carries a real instruction only when decode marked it valid
    // and (if enabled) its condition passed; otherwise it becomes a bubble
    always_comb begin
        load_ok        = valid_in && cond_pass;
        bubble_cnt_inc = (&bubble_cnt_out) ? bubble_cnt_out
                                           : bubble_cnt_out + 1'b1;
    end

    // Pipeline register: reset > flush > stall > load
    always_ff @(posedge clk) begin
        if (!reset) begin
            reg_write_enable_out  <= 1'b0;
            mem_write_enable_out  <= 1'b0;
            mem_to_reg_select_out <= 1'b0;
            alu_src_select_out    <= 1'b0;
            alu_control_out       <= '0;
            status_bits_out       <= 1'b0;
            rn_data_out           <= '0;
            rm_data_out           <= '0;
            imm_out               <= '0;
            rd_addr_out           <= '0;
            valid_out             <= 1'b0;
            cond_fail_out         <= 1'b0;
            bubble_cnt_out        <= '0;
        end else if (flush) begin
            reg_write_enable_out  <= 1'b0;
            mem_write_enable_out  <= 1'b0;
            mem_to_reg_select_out <= 1'b0;
            alu_src_select_out    <= 1'b0;
            alu_control_out       <= '0;
            status_bits_out       <= 1'b0;
            rn_data_out           <= '0;
            rm_data_out           <= '0;
            imm_out               <= '0;
            rd_addr_out           <= '0;
            valid_out             <= 1'b0;
            cond_fail_out         <= 1'b0;
            bubble_cnt_out        <= bubble_cnt_inc;
        end else if (!stall) begin
            reg_write_enable_out  <= load_ok && reg_write_enable_in;
            mem_write_enable_out  <= load_ok && mem_write_enable_in;
            mem_to_reg_select_out <= load_ok && mem_to_reg_select_in;
            alu_src_select_out    <= load_ok && alu_src_select_in;
            alu_control_out       <= load_ok ? alu_control_in : 2'b00;
            status_bits_out       <= load_ok && status_bits_in;
            rn_data_out           <= rn_data_in;
            rm_data_out           <= rm_data_in;
            imm_out               <= imm_in;
            rd_addr_out           <= rd_addr_in;
            valid_out             <= load_ok;
            cond_fail_out         <= valid_in && !cond_pass;
            if (!load_ok) begin
                bubble_cnt_out <= bubble_cnt_inc;
            end
        end
    end

endmodule

// File: tb/tb_id_ex_reg.sv
// tb_id_ex_reg: scoreboard bench for id_ex_reg.
// Expected outputs are produced by a behavioural model when inputs are
// driven, queued, and compared one cycle later against the DUT.
module tb_id_ex_reg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 4;
    localparam int CNT_W  = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              stall;
    logic              flush;
    logic              valid_in;
    logic              reg_write_enable_in;
    logic              mem_write_enable_in;
    logic              mem_to_reg_select_in;
    logic              alu_src_select_in;
    logic [1:0]        alu_control_in;
    logic              status_bits_in;
    logic [DATA_W-1:0] rn_data_in;
    logic [DATA_W-1:0] rm_data_in;
    logic [DATA_W-1:0] imm_in;
    logic [ADDR_W-1:0] rd_addr_in;
    logic [3:0]        cond_in;
    logic [3:0]        flags_in;
    logic              reg_write_enable_out;
    logic              mem_write_enable_out;
    logic              mem_to_reg_select_out;
    logic              alu_src_select_out;
    logic [1:0]        alu_control_out;
    logic              status_bits_out;
    logic [DATA_W-1:0] rn_data_out;
    logic [DATA_W-1:0] rm_data_out;
    logic [DATA_W-1:0] imm_out;
    logic [ADDR_W-1:0] rd_addr_out;
    logic              valid_out;
    logic              cond_fail_out;
    logic [CNT_W-1:0]  bubble_cnt_out;

    typedef struct {
        logic              rw;
        logic              mw;
        logic              m2r;
        logic              asrc;
        logic [1:0]        alu;
        logic              sb;
        logic [DATA_W-1:0] rn;
        logic [DATA_W-1:0] rm;
        logic [DATA_W-1:0] imm;
        logic [ADDR_W-1:0] rd;
        logic              valid;
        logic              cfail;
        logic [CNT_W-1:0]  cnt;
    } exp_t;

    exp_t mdl;
    exp_t sb_q[$];
    int   check_count = 0;
    int   pass_count  = 0;

    id_ex_reg #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk                   (clk),
        .reset                 (reset),
        .stall                 (stall),
        .flush                 (flush),
        .valid_in              (valid_in),
        .reg_write_enable_in   (reg_write_enable_in),
        .mem_write_enable_in   (mem_write_enable_in),
        .mem_to_reg_select_in  (mem_to_reg_select_in),
        .alu_src_select_in     (alu_src_select_in),
        .alu_control_in        (alu_control_in),
        .status_bits_in        (status_bits_in),
        .rn_data_in            (rn_data_in),
        .rm_data_in            (rm_data_in),
        .imm_in                (imm_in),
        .rd_addr_in            (rd_addr_in),
        .cond_in               (cond_in),
        .flags_in              (flags_in),
        .reg_write_enable_out  (reg_write_enable_out),
        .mem_write_enable_out  (mem_write_enable_out),
        .mem_to_reg_select_out (mem_to_reg_select_out),
        .alu_src_select_out    (alu_src_select_out),
        .alu_control_out       (alu_control_out),
        .status_bits_out       (status_bits_out),
        .rn_data_out           (rn_data_out),
        .rm_data_out           (rm_data_out),
        .imm_out               (imm_out),
        .rd_addr_out           (rd_addr_out),
        .valid_out             (valid_out),
        .cond_fail_out         (cond_fail_out),
        .bubble_cnt_out        (bubble_cnt_out)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    always #5 clk = ~clk;

    // Condition-code reference table, flags ordered {N,Z,C,V}
    function automatic logic condModel(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v;
        n  = f[3];
        z  = f[2];
        cy = f[1];
        v  = f[0];
        case (c)
            4'd0:    return z;
            4'd1:    return ~z;
            4'd2:    return cy;
            4'd3:    return ~cy;
            4'd4:    return n;
            4'd5:    return ~n;
            4'd6:    return v;
            4'd7:    return ~v;
            4'd8:    return cy & ~z;
            4'd9:    return ~cy | z;
            4'd10:   return ~(n ^ v);
            4'd11:   return n ^ v;
            4'd12:   return ~z & ~(n ^ v);
            4'd13:   return z | (n ^ v);
            4'd14:   return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] c);
        return (c == {CNT_W{1'b1}}) ? c : c + 1'b1;
    endfunction

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        check_count++;
        if (obs === expv) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, expv, $time);
        end
    endtask

    task automatic compareOutputs(input exp_t e);
        checkOutput("reg_write", 64'(reg_write_enable_out), 64'(e.rw));
        checkOutput("mem_write", 64'(mem_write_enable_out), 64'(e.mw));
        checkOutput("mem_to_reg", 64'(mem_to_reg_select_out), 64'(e.m2r));
        checkOutput("alu_src", 64'(alu_src_select_out), 64'(e.asrc));
        checkOutput("alu_control", 64'(alu_control_out), 64'(e.alu));
        checkOutput("status_bits", 64'(status_bits_out), 64'(e.sb));
        checkOutput("rn_data", 64'(rn_data_out), 64'(e.rn));
        checkOutput("rm_data", 64'(rm_data_out), 64'(e.rm));
        checkOutput("imm", 64'(imm_out), 64'(e.imm));
        checkOutput("rd_addr", 64'(rd_addr_out), 64'(e.rd));
        checkOutput("valid", 64'(valid_out), 64'(e.valid));
        checkOutput("cond_fail", 64'(cond_fail_out), 64'(e.cfail));
        checkOutput("bubble_cnt", 64'(bubble_cnt_out), 64'(e.cnt));
    endtask

    // Advance the model with the currently driven inputs, queue the
    // expectation, clock once and compare just after the edge
    task automatic applyStimulus();
        logic       pass;
        logic       load_ok;
        logic [CNT_W-1:0] keep;
        exp_t       e;
        if (!reset) begin
            mdl = '{default: '0};
        end else if (flush) begin
            keep    = mdl.cnt;
            mdl     = '{default: '0};
            mdl.cnt = satInc(keep);
        end else if (!stall) begin
`ifdef COND_EXEC_EN
            pass = condModel(cond_in, flags_in);
`else
            pass = 1'b1;
`endif
            load_ok   = valid_in & pass;
            mdl.rw    = load_ok ? reg_write_enable_in : 1'b0;
            mdl.mw    = load_ok ? mem_write_enable_in : 1'b0;
            mdl.m2r   = load_ok ? mem_to_reg_select_in : 1'b0;
            mdl.asrc  = load_ok ? alu_src_select_in : 1'b0;
            mdl.alu   = load_ok ? alu_control_in : 2'b00;
            mdl.sb    = load_ok ? status_bits_in : 1'b0;
            mdl.rn    = rn_data_in;
            mdl.rm    = rm_data_in;
            mdl.imm   = imm_in;
            mdl.rd    = rd_addr_in;
            mdl.valid = load_ok;
            mdl.cfail = valid_in & ~pass;
            if (!load_ok) mdl.cnt = satInc(mdl.cnt);
        end
        sb_q.push_back(mdl);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        compareOutputs(e);
    endtask

    task automatic randomInputs();
        valid_in             = 1'($urandom);
        reg_write_enable_in  = 1'($urandom);
        mem_write_enable_in  = 1'($urandom);
        mem_to_reg_select_in = 1'($urandom);
        alu_src_select_in    = 1'($urandom);
        alu_control_in       = 2'($urandom);
        status_bits_in       = 1'($urandom);
        rn_data_in           = $urandom;
        rm_data_in           = $urandom;
        imm_in               = $urandom;
        rd_addr_in           = 4'($urandom);
        cond_in              = 4'($urandom);
        flags_in             = 4'($urandom);
    endtask

    task automatic clearInputs();
        stall = 0; flush = 0; valid_in = 0;
        reg_write_enable_in = 0; mem_write_enable_in = 0;
        mem_to_reg_select_in = 0; alu_src_select_in = 0;
        alu_control_in = 2'b00; status_bits_in = 0;
        rn_data_in = '0; rm_data_in = '0; imm_in = '0; rd_addr_in = '0;
        cond_in = 4'b1110; flags_in = 4'b0000;
    endtask

    initial begin
        mdl = '{default: '0};

        // Reset with every other input high
        reset = 0; stall = 1; flush = 1; valid_in = 1;
        reg_write_enable_in = 1; mem_write_enable_in = 1;
        mem_to_reg_select_in = 1; alu_src_select_in = 1;
        alu_control_in = 2'b11; status_bits_in = 1;
        rn_data_in = '1; rm_data_in = '1; imm_in = '1; rd_addr_in = '1;
        cond_in = 4'hF; flags_in = 4'hF;
        applyStimulus();
        checkOutput("reset_cnt", 64'(bubble_cnt_out), 64'd0);
        checkOutput("reset_valid", 64'(valid_out), 64'd0);

        // Basic load
        reset = 1;
        clearInputs();
        valid_in = 1; reg_write_enable_in = 1; alu_control_in = 2'b10;
        rn_data_in = 32'h1234;
        applyStimulus();
        checkOutput("load_rn", 64'(rn_data_out), 64'h1234);
        checkOutput("load_valid", 64'(valid_out), 64'd1);
        checkOutput("load_alu", 64'(alu_control_out), 64'd2);

        // Stall for three cycles while inputs change
        for (int i = 0; i < 3; i++) begin
            randomInputs();
            stall = 1; flush = 0;
            applyStimulus();
        end
        checkOutput("stall_rn", 64'(rn_data_out), 64'h1234);
        checkOutput("stall_cnt", 64'(bubble_cnt_out), 64'd0);

        // Stall and flush together: flush wins
        randomInputs();
        stall = 1; flush = 1;
        applyStimulus();
        checkOutput("sf_valid", 64'(valid_out), 64'd0);
        checkOutput("sf_cnt", 64'(bubble_cnt_out), 64'd1);

        // Long run of flushes saturates the counter
        for (int i = 0; i < 300; i++) begin
            randomInputs();
            stall = 0; flush = 1;
            applyStimulus();
        end
        checkOutput("sat_cnt", 64'(bubble_cnt_out), 64'd255);

        // Condition check: EQ with Z clear, then with Z set
        clearInputs();
        valid_in = 1; reg_write_enable_in = 1; alu_control_in = 2'b01;
        rn_data_in = 32'hCAFE; rd_addr_in = 4'd7;
        cond_in = 4'b0000; flags_in = 4'b0000;
        applyStimulus();
`ifdef COND_EXEC_EN
        checkOutput("eq_fail_flag", 64'(cond_fail_out), 64'd1);
        checkOutput("eq_fail_valid", 64'(valid_out), 64'd0);
        checkOutput("eq_fail_rw", 64'(reg_write_enable_out), 64'd0);
`else
        checkOutput("eq_nocond_flag", 64'(cond_fail_out), 64'd0);
        checkOutput("eq_nocond_valid", 64'(valid_out), 64'd1);
`endif
        checkOutput("eq_rd_captured", 64'(rd_addr_out), 64'd7);
        flags_in = 4'b0100;
        applyStimulus();
        checkOutput("eq_pass_flag", 64'(cond_fail_out), 64'd0);
        checkOutput("eq_pass_valid", 64'(valid_out), 64'd1);

        // Reset arriving during a stall discards the held instruction
        clearInputs();
        valid_in = 1; mem_write_enable_in = 1; rn_data_in = 32'h55AA;
        applyStimulus();
        stall = 1;
        applyStimulus();
        reset = 0;
        applyStimulus();
        checkOutput("rst_stall_rn", 64'(rn_data_out), 64'd0);
        checkOutput("rst_stall_cnt", 64'(bubble_cnt_out), 64'd0);
        reset = 1;

        // Mixed random traffic
        for (int i = 0; i < 200; i++) begin
            randomInputs();
            stall = ($urandom_range(0, 5) == 0);
            flush = ($urandom_range(0, 7) == 0);
            reset = ($urandom_range(0, 60) != 0);
            applyStimulus();
        end

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
